umem_arb: RTL and testbench

Parametrised unified memory for the simprisc core: a DEPTH x DATA_W word array shared by NUM_CH CPU-side request/grant channels (channel 0 = instruction fetch, channel 1 = load/store, further channels optional) and the AXI loader write port. Replaces the single fixed mem_addr/mem_rw bus with arbitrated, pipelined, byte-enabled access. After reset an optional scrub pass zeroes the array. Sits between the core's memory stage and the AXI-side program loader.

---
 rtl/umem_pkg.sv | 21 ++
 rtl/umem_arb_if.sv | 32 +++
 rtl/umem_rr_arb.sv | 31 +++
 rtl/umem_arb.sv | 176 +++++++++++++++++
 tb/tb_umem_arb.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/umem_pkg.sv
// Shared types and constants for the unified memory arbiter.
// Build option: UMEM_SCRUB_EN enables the post-reset zeroing pass.
package umem_pkg;

   typedef enum logic {
      SCRUB = 1'b0,
      RUN   = 1'b1
   } state_t;

   localparam int MAX_CH     = 8;
   localparam int MAX_RD_LAT = 4;

   function automatic logic [7:0] merge_byte(
      input logic [7:0] i_old,
      input logic [7:0] i_new,
      input logic       i_be
   );
      return i_be ? i_new : i_old;
   endfunction

endpackage

// File: rtl/umem_arb_if.sv
// CPU channel and loader bus for umem_arb.
// master = core/loader side, slave = memory side.
interface umem_arb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9,
   parameter int NUM_CH = 2
);
   logic                       axi_mem_w;
   logic [ADDR_W-1:0]          axi_mem_addr;
   logic [DATA_W-1:0]          axi_mem_data;
   logic [NUM_CH-1:0]          ch_req;
   logic [NUM_CH-1:0]          ch_we;
   logic [NUM_CH*ADDR_W-1:0]   ch_addr;
   logic [NUM_CH*DATA_W-1:0]   ch_wdata;
   logic [NUM_CH*DATA_W/8-1:0] ch_be;
   logic [NUM_CH-1:0]          ch_gnt;
   logic [NUM_CH-1:0]          ch_rvalid;
   logic [DATA_W-1:0]          ch_rdata;
   logic                       init_done;

   modport master (
      output axi_mem_w, axi_mem_addr, axi_mem_data,
      output ch_req, ch_we, ch_addr, ch_wdata, ch_be,
      input  ch_gnt, ch_rvalid, ch_rdata, init_done
   );

   modport slave (
      input  axi_mem_w, axi_mem_addr, axi_mem_data,
      input  ch_req, ch_we, ch_addr, ch_wdata, ch_be,
      output ch_gnt, ch_rvalid, ch_rdata, init_done
   );
endinterface

// File: rtl/umem_rr_arb.sv
// Round-robin arbiter; search starts just above the last granted channel.
// Pointer kept as a mask of channels at or above the search start.
module umem_rr_arb import umem_pkg::*; #(
   parameter int NUM_CH = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] i_req,
   input  logic              i_en,
   output logic [NUM_CH-1:0] o_gnt
);
   logic [NUM_CH-1:0] r_mask;
   logic [NUM_CH-1:0] w_hi;
   logic [NUM_CH-1:0] w_pick;
   logic [NUM_CH-1:0] w_sh;
   logic [NUM_CH-1:0] w_nmask;

   always_comb begin
      w_hi = i_req & r_mask;
      if (|w_hi) w_pick = w_hi & (~w_hi + NUM_CH'(1));
      else       w_pick = i_req & (~i_req + NUM_CH'(1));
      o_gnt   = i_en ? w_pick : '0;
      w_sh    = o_gnt << 1;
      w_nmask = ~(w_sh - NUM_CH'(1));
   end

   always_ff @(posedge clk) begin
      if (reset)       r_mask <= '1;
      else if (|o_gnt) r_mask <= w_nmask;
   end
endmodule

// File: rtl/umem_arb.sv
// Unified word memory shared by NUM_CH CPU channels and the AXI loader.
// Define UMEM_SCRUB_EN to zero the array after reset before serving requests.
module umem_arb import umem_pkg::*; #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9,
   parameter int NUM_CH = 2,
   parameter int RD_LAT = 1
) (
   input  logic       clk,
   input  logic       reset,
   umem_arb_if.slave  bus
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam int BW    = DATA_W / 8;

   if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_ch
      $error("NUM_CH out of range");
   end
   if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_lat
      $error("RD_LAT out of range");
   end

`ifdef UMEM_SCRUB_EN
   localparam state_t RST_ST = SCRUB;
`else
   localparam state_t RST_ST = RUN;
`endif

   state_t r_state;
   state_t w_state_nxt;
   logic   w_scrub;
   logic   w_run;
   logic   w_load;
   logic   w_en;

   logic [DATA_W-1:0] r_mem [DEPTH];

   logic [NUM_CH-1:0] w_gnt;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;
   logic [BW-1:0]     w_sel_be;
   logic              w_rd;

   logic              w_wr_en;
   logic [ADDR_W-1:0] w_wr_addr;
   logic [DATA_W-1:0] w_wr_data;
   logic [BW-1:0]     w_wr_be;
   logic [DATA_W-1:0] w_old;
   logic [DATA_W-1:0] w_merged;

   logic              r_pv [RD_LAT];
   logic [NUM_CH-1:0] r_pc [RD_LAT];
   logic [DATA_W-1:0] r_pd [RD_LAT];

`ifdef UMEM_SCRUB_EN
   logic [ADDR_W-1:0] r_scrub_cnt;

   always_ff @(posedge clk) begin
      if (reset)                 r_scrub_cnt <= '0;
      else if (r_state == SCRUB) r_scrub_cnt <= r_scrub_cnt + 1'b1;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_scrub     = 1'b0;
      unique case (r_state)
         SCRUB: begin
            w_scrub = !reset;
            if (r_scrub_cnt == ADDR_W'(DEPTH - 1)) w_state_nxt = RUN;
         end
         RUN:     w_state_nxt = RUN;
         default: w_state_nxt = RST_ST;
      endcase
   end
`else
   always_comb begin
      w_state_nxt = RUN;
      w_scrub     = 1'b0;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) r_state <= RST_ST;
      else       r_state <= w_state_nxt;
   end

   assign w_run  = (r_state == RUN) && !reset;
   assign w_load = w_run && bus.axi_mem_w;
   assign w_en   = w_run && !bus.axi_mem_w;

   umem_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
      .clk   (clk),
      .reset (reset),
      .i_req (bus.ch_req),
      .i_en  (w_en),
      .o_gnt (w_gnt)
   );

   always_comb begin
      w_sel_we    = 1'b0;
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      w_sel_be    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_gnt[i]) begin
            w_sel_we    = bus.ch_we[i];
            w_sel_addr  = bus.ch_addr[i*ADDR_W +: ADDR_W];
            w_sel_wdata = bus.ch_wdata[i*DATA_W +: DATA_W];
            w_sel_be    = bus.ch_be[i*BW +: BW];
         end
      end
   end

   assign w_rd = (|w_gnt) && !w_sel_we;

   always_comb begin
      w_wr_en   = 1'b0;
      w_wr_addr = w_sel_addr;
      w_wr_data = w_sel_wdata;
      w_wr_be   = w_sel_be;
      if (w_scrub) begin
`ifdef UMEM_SCRUB_EN
         w_wr_en   = 1'b1;
         w_wr_addr = r_scrub_cnt;
         w_wr_data = '0;
         w_wr_be   = '1;
`endif
      end else if (w_load) begin
         w_wr_en   = 1'b1;
         w_wr_addr = bus.axi_mem_addr;
         w_wr_data = bus.axi_mem_data;
         w_wr_be   = '1;
      end else if ((|w_gnt) && w_sel_we) begin
         w_wr_en   = 1'b1;
      end
   end

   always_comb begin
      w_old    = r_mem[w_wr_addr];
      w_merged = '0;
      for (int b = 0; b < BW; b++) begin
         w_merged[8*b +: 8] =
            merge_byte(w_old[8*b +: 8], w_wr_data[8*b +: 8], w_wr_be[b]);
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[w_wr_addr] <= w_merged;
   end

   // data only advances with a valid beat so the output word holds
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < RD_LAT; i++) begin
            r_pv[i] <= 1'b0;
            r_pc[i] <= '0;
            r_pd[i] <= '0;
         end
      end else begin
         r_pv[0] <= w_rd;
         r_pc[0] <= w_gnt;
         if (w_rd) r_pd[0] <= r_mem[w_sel_addr];
         for (int i = 1; i < RD_LAT; i++) begin
            r_pv[i] <= r_pv[i-1];
            r_pc[i] <= r_pc[i-1];
            if (r_pv[i-1]) r_pd[i] <= r_pd[i-1];
         end
      end
   end

   assign bus.ch_gnt    = w_gnt;
   assign bus.ch_rvalid = r_pv[RD_LAT-1] ? r_pc[RD_LAT-1] : '0;
   assign bus.ch_rdata  = r_pd[RD_LAT-1];
   assign bus.init_done = (r_state == RUN) && !reset;
endmodule

// File: tb/tb_umem_arb.sv
// Self-checking bench for umem_arb: directed scenarios plus a
// randomized run against a behavioural memory/round-robin model.
module tb_umem_arb;
   localparam int DW   = 32;
   localparam int AW   = 9;
   localparam int NC   = 2;
   localparam int LAT  = 2;
   localparam int LAT3 = 3;
   localparam int NR   = 400;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   umem_arb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC)) bus ();
   umem_arb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC)) bus3 ();

   umem_arb #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC), .RD_LAT(LAT)) dut (
      .clk(clk), .reset(reset), .bus(bus));
   umem_arb #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC), .RD_LAT(LAT3)) dut3 (
      .clk(clk), .reset(reset), .bus(bus3));

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      int          due;
      int          ch;
      logic [31:0] d;
   } exp_t;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle();
      bus.axi_mem_w = 0; bus.axi_mem_addr = '0; bus.axi_mem_data = '0;
      bus.ch_req = '0; bus.ch_we = '0; bus.ch_addr = '0;
      bus.ch_wdata = '0; bus.ch_be = '0;
      bus3.axi_mem_w = 0; bus3.axi_mem_addr = '0; bus3.axi_mem_data = '0;
      bus3.ch_req = '0; bus3.ch_we = '0; bus3.ch_addr = '0;
      bus3.ch_wdata = '0; bus3.ch_be = '0;
   endtask

   task automatic set_ch(input int ch, input logic req, input logic we,
                         input logic [8:0] a, input logic [31:0] d,
                         input logic [3:0] be);
      bus.ch_req[ch]            = req;
      bus.ch_we[ch]             = we;
      bus.ch_addr[ch*AW +: AW]  = a;
      bus.ch_wdata[ch*DW +: DW] = d;
      bus.ch_be[ch*4 +: 4]      = be;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_reset(output bit ok);
      idle();
      reset = 1;
      step();
      reset = 0;
      ok = 0;
      for (int i = 0; i < 700; i++) begin
         if (bus.init_done && bus3.init_done) begin
            ok = 1;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      int low;
      idle();
      reset = 1;
      bus.ch_req = 2'b11;
      step();
      n_cmp++; if (bus.ch_gnt !== 2'b00) begin n_err++;
         $display("FAIL rst_gnt: got %b want 00", bus.ch_gnt); end
      n_cmp++; if (bus.ch_rvalid !== 2'b00) begin n_err++;
         $display("FAIL rst_rvalid: got %b want 00", bus.ch_rvalid); end
      n_cmp++; if (bus.ch_rdata !== 32'h0) begin n_err++;
         $display("FAIL rst_rdata: got %h want 0", bus.ch_rdata); end
      n_cmp++; if (bus.init_done !== 1'b0) begin n_err++;
         $display("FAIL rst_init: got %b want 0", bus.init_done); end
      reset = 0;
      bus.ch_req = 2'b00;
`ifdef UMEM_SCRUB_EN
      low = 0;
      while (!bus.init_done && low < 700) begin
         if (low == 100) begin
            bus.ch_req = 2'b01;
            #1;
            n_cmp++; if (bus.ch_gnt !== 2'b00) begin n_err++;
               $display("FAIL scrub_gnt: got %b want 00", bus.ch_gnt); end
            bus.ch_req = 2'b00;
         end
         low++;
         step();
      end
      n_cmp++; if (low !== 512) begin n_err++;
         $display("FAIL scrub_len: got %0d want 512", low); end
      set_ch(0, 1, 0, 9'h1FF, 0, 0);
      #1;
      n_cmp++; if (bus.ch_gnt !== 2'b01) begin n_err++;
         $display("FAIL scrub_rd_gnt: got %b want 01", bus.ch_gnt); end
      step();
      idle();
      repeat (LAT - 1) step();
      n_cmp++; if (bus.ch_rvalid !== 2'b01 || bus.ch_rdata !== 32'h0) begin
         n_err++;
         $display("FAIL scrub_rd: got v=%b d=%h want v=01 d=0",
                  bus.ch_rvalid, bus.ch_rdata); end
`else
      low = 0;
      #1;
      n_cmp++; if (bus.init_done !== 1'b1) begin n_err++;
         $display("FAIL init_after_rst: got %b want 1", bus.init_done); end
`endif
      while (!bus3.init_done && low < 1400) begin low++; step(); end
   endtask

   task automatic test_loader_priority();
      idle();
      bus.axi_mem_w = 1; bus.axi_mem_addr = 9'h010;
      bus.axi_mem_data = 32'hDEADBEEF;
      set_ch(0, 1, 0, 9'h010, 0, 0);
      set_ch(1, 1, 0, 9'h004, 0, 0);
      #1;
      n_cmp++; if (bus.ch_gnt !== 2'b00) begin n_err++;
         $display("FAIL ldr_gnt: got %b want 00", bus.ch_gnt); end
      step();
      idle();
      set_ch(0, 1, 0, 9'h010, 0, 0);
      #1;
      n_cmp++; if (bus.ch_gnt !== 2'b01) begin n_err++;
         $display("FAIL ldr_rd_gnt: got %b want 01", bus.ch_gnt); end
      step();
      idle();
      repeat (LAT - 1) step();
      n_cmp++; if (bus.ch_rvalid !== 2'b01 || bus.ch_rdata !== 32'hDEADBEEF)
      begin n_err++;
         $display("FAIL ldr_rd: got v=%b d=%h want v=01 d=deadbeef",
                  bus.ch_rvalid, bus.ch_rdata); end
   endtask

   task automatic test_byte_enable();
      idle();
      set_ch(0, 1, 1, 9'h004, 32'h11223344, 4'hF);
      #1;
      n_cmp++; if (bus.ch_gnt !== 2'b01) begin n_err++;
         $display("FAIL be_w0_gnt: got %b want 01", bus.ch_gnt); end
      step();
      idle();
      set_ch(1, 1, 1, 9'h004, 32'hAABBCCDD, 4'b0101);
      #1;
      n_cmp++; if (bus.ch_gnt !== 2'b10) begin n_err++;
         $display("FAIL be_w1_gnt: got %b want 10", bus.ch_gnt); end
      step();
      set_ch(1, 1, 1, 9'h004, 32'hFFFFFFFF, 4'b0000);
      #1;
      n_cmp++; if (bus.ch_gnt !== 2'b10) begin n_err++;
         $display("FAIL be_noop_gnt: got %b want 10", bus.ch_gnt); end
      step();
      idle();
      set_ch(0, 1, 0, 9'h004, 0, 0);
      step();
      idle();
      repeat (LAT - 1) step();
      n_cmp++; if (bus.ch_rvalid !== 2'b01 || bus.ch_rdata !== 32'h11BB33DD)
      begin n_err++;
         $display("FAIL be_rd: got v=%b d=%h want v=01 d=11bb33dd",
                  bus.ch_rvalid, bus.ch_rdata); end
   endtask

   task automatic test_round_robin();
      bit ok;
      logic [1:0]  eg;
      logic [1:0]  ev;
      logic [31:0] ed;
      int j;
      do_reset(ok);
      n_cmp++; if (!ok) begin n_err++;
         $display("FAIL rr_reset_init: init_done %b want 1", bus.init_done); end
      set_ch(0, 1, 0, 9'h010, 0, 0);
      set_ch(1, 1, 0, 9'h004, 0, 0);
      for (int k = 0; k < 3 + LAT; k++) begin
         if (k == 4) idle();
         if (k < 4) begin
            eg = (k % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            n_cmp++; if (bus.ch_gnt !== eg) begin n_err++;
               $display("FAIL rr_gnt%0d: got %b want %b", k, bus.ch_gnt, eg);
            end
         end
         step();
         j = k + 1;
         ev = 2'b00;
         if (j >= LAT && j - LAT < 4)
            ev = ((j - LAT) % 2 == 0) ? 2'b01 : 2'b10;
`ifdef UMEM_SCRUB_EN
         ed = 32'h0;
`else
         ed = (ev == 2'b01) ? 32'hDEADBEEF : 32'h11BB33DD;
`endif
         n_cmp++; if (bus.ch_rvalid !== ev) begin n_err++;
            $display("FAIL rr_rvalid%0d: got %b want %b", j, bus.ch_rvalid, ev);
         end
         if (ev != 2'b00) begin
            n_cmp++; if (bus.ch_rdata !== ed) begin n_err++;
               $display("FAIL rr_rdata%0d: got %h want %h", j, bus.ch_rdata, ed);
            end
         end
      end
      idle();
   endtask

   task automatic test_rd_lat3();
      logic [1:0] ev;
      idle();
      bus3.axi_mem_w = 1; bus3.axi_mem_addr = 9'h020;
      bus3.axi_mem_data = 32'h5A5AA5A5;
      step();
      idle();
      bus3.ch_req = 2'b10; bus3.ch_we = 2'b00;
      bus3.ch_addr = {9'h020, 9'h000};
      #1;
      n_cmp++; if (bus3.ch_gnt !== 2'b10) begin n_err++;
         $display("FAIL lat3_gnt: got %b want 10", bus3.ch_gnt); end
      step();
      idle();
      for (int c = 1; c <= 5; c++) begin
         ev = (c == LAT3) ? 2'b10 : 2'b00;
         n_cmp++; if (bus3.ch_rvalid !== ev) begin n_err++;
            $display("FAIL lat3_rvalid_n%0d: got %b want %b", c,
                     bus3.ch_rvalid, ev); end
         if (c == LAT3) begin
            n_cmp++; if (bus3.ch_rdata !== 32'h5A5AA5A5) begin n_err++;
               $display("FAIL lat3_rdata: got %h want 5a5aa5a5", bus3.ch_rdata);
            end
         end
         step();
      end
   endtask

   task automatic test_reset_mid_read();
      int seen;
      int w;
      idle();
      bus.axi_mem_w = 1; bus.axi_mem_addr = 9'h010;
      bus.axi_mem_data = 32'hCAFEF00D;
      step();
      idle();
      set_ch(0, 1, 0, 9'h010, 0, 0);
      #1;
      n_cmp++; if (bus.ch_gnt !== 2'b01) begin n_err++;
         $display("FAIL mid_gnt: got %b want 01", bus.ch_gnt); end
      step();
      idle();
      reset = 1;
      step();
      reset = 0;
      n_cmp++; if (bus.ch_rvalid !== 2'b00 || bus.ch_rdata !== 32'h0) begin
         n_err++;
         $display("FAIL mid_flush: got v=%b d=%h want v=00 d=0",
                  bus.ch_rvalid, bus.ch_rdata); end
      seen = 0;
      w = 0;
      while (!bus.init_done && w < 700) begin
         if (bus.ch_rvalid != 2'b00) seen++;
         w++;
         step();
      end
      n_cmp++; if (!bus.init_done) begin n_err++;
         $display("FAIL mid_init: got %b want 1", bus.init_done); end
      repeat (LAT + 1) begin
         if (bus.ch_rvalid != 2'b00) seen++;
         step();
      end
      n_cmp++; if (seen !== 0) begin n_err++;
         $display("FAIL mid_no_rvalid: got %0d beats want 0", seen); end
      set_ch(0, 1, 0, 9'h000, 0, 0);
      set_ch(1, 1, 0, 9'h001, 0, 0);
      #1;
      n_cmp++; if (bus.ch_gnt !== 2'b01) begin n_err++;
         $display("FAIL mid_rr_ptr: got %b want 01", bus.ch_gnt); end
      step();
      idle();
      repeat (LAT + 1) step();
   endtask

   task automatic test_random();
      bit          ok;
      logic [31:0] mdl [16];
      logic        p_req [2];
      logic        p_we [2];
      logic [8:0]  p_a [2];
      logic [31:0] p_d [2];
      logic [3:0]  p_be [2];
      exp_t        q [$];
      exp_t        e;
      int          ptr;
      int          g;
      int          c;
      logic        ld;
      logic [8:0]  la;
      logic [31:0] ldat;
      logic [1:0]  eg;
      logic [1:0]  ev;
      logic [31:0] last;
      bit          have_last;
      do_reset(ok);
      n_cmp++; if (!ok) begin n_err++;
         $display("FAIL rnd_reset_init: init_done %b want 1", bus.init_done); end
      for (int a = 0; a < 16; a++) begin
         mdl[a] = $urandom;
         bus.axi_mem_w = 1; bus.axi_mem_addr = 9'(a);
         bus.axi_mem_data = mdl[a];
         step();
      end
      idle();
      for (int i = 0; i < 2; i++) begin
         p_req[i] = 0; p_we[i] = 0; p_a[i] = '0; p_d[i] = '0; p_be[i] = '0;
      end
      ptr = 0;
      have_last = 0;
      last = '0;
      for (int t = 0; t < NR + LAT; t++) begin
         if (t < NR) begin
            for (int ch = 0; ch < 2; ch++) begin
               if (!p_req[ch] && $urandom_range(0, 1) == 1) begin
                  p_req[ch] = 1;
                  p_we[ch]  = 1'($urandom_range(0, 1));
                  p_a[ch]   = 9'($urandom_range(0, 15));
                  p_d[ch]   = $urandom;
                  p_be[ch]  = 4'($urandom_range(0, 15));
               end
            end
         end
         ld   = (t < NR) && ($urandom_range(0, 4) == 0);
         la   = 9'($urandom_range(0, 15));
         ldat = $urandom;
         bus.axi_mem_w = ld; bus.axi_mem_addr = la; bus.axi_mem_data = ldat;
         bus.ch_req   = {p_req[1], p_req[0]};
         bus.ch_we    = {p_we[1], p_we[0]};
         bus.ch_addr  = {p_a[1], p_a[0]};
         bus.ch_wdata = {p_d[1], p_d[0]};
         bus.ch_be    = {p_be[1], p_be[0]};
         #1;
         g = -1;
         if (!ld) begin
            for (int i = 0; i < 2; i++) begin
               c = (ptr + i) % 2;
               if (g < 0 && p_req[c]) g = c;
            end
         end
         eg = (g >= 0) ? (2'b01 << g) : 2'b00;
         n_cmp++; if (bus.ch_gnt !== eg) begin n_err++;
            $display("FAIL rnd_gnt t=%0d: got %b want %b", t, bus.ch_gnt, eg);
         end
         if (ld) mdl[la[3:0]] = ldat;
         else if (g >= 0) begin
            if (p_we[g]) begin
               for (int b = 0; b < 4; b++)
                  if (p_be[g][b]) mdl[p_a[g][3:0]][8*b +: 8] = p_d[g][8*b +: 8];
            end else begin
               e.due = t + LAT; e.ch = g; e.d = mdl[p_a[g][3:0]];
               q.push_back(e);
            end
            ptr = (g + 1) % 2;
            p_req[g] = 0;
         end
         step();
         ev = 2'b00;
         if (q.size() > 0 && q[0].due == t + 1) begin
            e = q.pop_front();
            ev = 2'b01 << e.ch;
            last = e.d;
            have_last = 1;
         end
         n_cmp++; if (bus.ch_rvalid !== ev) begin n_err++;
            $display("FAIL rnd_rvalid t=%0d: got %b want %b", t + 1,
                     bus.ch_rvalid, ev); end
         if (have_last) begin
            n_cmp++; if (bus.ch_rdata !== last) begin n_err++;
               $display("FAIL rnd_rdata t=%0d: got %h want %h", t + 1,
                        bus.ch_rdata, last); end
         end
      end
      n_cmp++; if (q.size() !== 0) begin n_err++;
         $display("FAIL rnd_drain: got %0d pending want 0", q.size()); end
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_loader_priority();
      test_byte_enable();
      test_round_robin();
      test_rd_lat3();
      test_reset_mid_read();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
